// File: rtl/vip_win_pkg.sv
// vip_win_pkg: shared FSM encoding, counter width and window flag bit positions
package vip_win_pkg;
    localparam int CNT_W = 11;
    localparam int FLAG_W = 4;
    localparam int FLAG_TOP = 0;
    localparam int FLAG_BOT = 1;
    localparam int FLAG_LEFT = 2;
    localparam int FLAG_RIGHT = 3;
    typedef enum logic [2:0] {IDLE, ACTIVE, FLUSH_WAIT, FLUSH, DONE} state_t;
endpackage

// File: rtl/vip_window_ctrl_if.sv
// vip_window_ctrl_if: video timing inputs plus window position and frame status outputs
interface vip_window_ctrl_if;
    logic in_vsync, in_href, in_clken;
    logic shift_en, buf_clr, win_valid;
    logic [vip_win_pkg::CNT_W-1:0] win_col, win_row;
    logic edge_top, edge_bot, edge_left, edge_right;
    logic flush_active, frame_done, frame_abort, seq_err;
    modport master (
        output in_vsync, in_href, in_clken,
        input shift_en, buf_clr, win_valid, win_col, win_row,
        input edge_top, edge_bot, edge_left, edge_right,
        input flush_active, frame_done, frame_abort, seq_err
    );
    modport slave (
        input in_vsync, in_href, in_clken,
        output shift_en, buf_clr, win_valid, win_col, win_row,
        output edge_top, edge_bot, edge_left, edge_right,
        output flush_active, frame_done, frame_abort, seq_err
    );
endinterface

// File: rtl/vip_edge_detect.sv
// vip_edge_detect: rise/fall pulses against a registered copy; a level already high at reset release is not a rise
module vip_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b1;
        else q <= d;
    end
    assign rise = d & ~q;
    assign fall = ~d & q;
endmodule

// File: rtl/vip_window_ctrl.sv
// vip_window_ctrl: 3x3 window sequencer that appends a synthetic flush line after each complete frame
module vip_window_ctrl
    import vip_win_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int FLUSH_GAP = 16
) (
    input logic clk,
    input logic rst_n,
    vip_window_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] H = CNT_W'(IMG_HDISP);
    localparam logic [CNT_W-1:0] V = CNT_W'(IMG_VDISP);
    localparam logic [15:0] GAP_LAST = 16'(FLUSH_GAP - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] px, px_nx, ln, ln_nx, col, row;
    logic [15:0] gap, gap_nx;
    logic [FLAG_W-1:0] flags, flags_nx;
    logic err_nx, acc, wv, vs_rise, vs_fall, hr_rise, hr_fall;
    vip_edge_detect u_vs (.clk(clk), .rst_n(rst_n), .d(bus.in_vsync), .rise(vs_rise), .fall(vs_fall));
    vip_edge_detect u_hr (.clk(clk), .rst_n(rst_n), .d(bus.in_href), .rise(hr_rise), .fall(hr_fall));
    assign acc = bus.in_href & bus.in_clken;
    always_comb begin
        state_nx = state;
        px_nx = px;
        ln_nx = ln;
        gap_nx = gap;
        err_nx = bus.seq_err;
        col = px;
        bus.shift_en = 1'b0;
        bus.buf_clr = 1'b0;
        bus.frame_done = 1'b0;
        bus.frame_abort = 1'b0;
        case (state)
            IDLE: begin
                px_nx = '0;
                ln_nx = '0;
                gap_nx = '0;
                if (vs_rise) begin
                    state_nx = ACTIVE;
                    bus.buf_clr = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_fall) begin
                    state_nx = IDLE;
                    bus.frame_abort = 1'b1;
                end else if (hr_fall) begin
                    px_nx = '0;
                    if (px == H) begin
                        ln_nx = ln + 1'b1;
                        if (ln_nx == V) state_nx = FLUSH_WAIT;
                    end else err_nx = 1'b1;
                end else if (acc) begin
                    col = hr_rise ? '0 : px;
                    // pixels beyond the line width saturate the column and flag an error
                    if (col == H) err_nx = 1'b1;
                    else begin
                        bus.shift_en = 1'b1;
                        px_nx = col + 1'b1;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (vs_fall) begin
                    state_nx = IDLE;
                    bus.frame_abort = 1'b1;
                end else begin
                    err_nx = bus.seq_err | acc;
                    gap_nx = gap + 1'b1;
                    if (gap == GAP_LAST) begin
                        gap_nx = '0;
                        px_nx = '0;
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (vs_fall) begin
                    state_nx = IDLE;
                    bus.frame_abort = 1'b1;
                end else begin
                    err_nx = bus.seq_err | acc;
                    bus.shift_en = 1'b1;
                    px_nx = px + 1'b1;
                    if (px == H - 1'b1) begin
                        px_nx = '0;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                bus.frame_done = 1'b1;
                err_nx = bus.seq_err | acc;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // the flush line replicates the bottom row, so its centre sits on the last real line
    assign row = (state == FLUSH) ? V - 1'b1 : ln - 1'b1;
    assign wv = bus.shift_en & ((state == FLUSH) | (ln != '0));
    always_comb begin
        flags_nx = '0;
        flags_nx[FLAG_TOP] = wv & (row == '0);
        flags_nx[FLAG_BOT] = wv & (row == V - 1'b1);
        flags_nx[FLAG_LEFT] = wv & (col == '0);
        flags_nx[FLAG_RIGHT] = wv & (col == H - 1'b1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            px <= '0;
            ln <= '0;
            gap <= '0;
            flags <= '0;
            bus.seq_err <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_col <= '0;
            bus.win_row <= '0;
        end else begin
            state <= state_nx;
            px <= px_nx;
            ln <= ln_nx;
            gap <= gap_nx;
            flags <= flags_nx;
            bus.seq_err <= err_nx;
            bus.win_valid <= wv;
            bus.win_col <= wv ? col : '0;
            bus.win_row <= wv ? row : '0;
        end
    end
    assign bus.edge_top = flags[FLAG_TOP];
    assign bus.edge_bot = flags[FLAG_BOT];
    assign bus.edge_left = flags[FLAG_LEFT];
    assign bus.edge_right = flags[FLAG_RIGHT];
    assign bus.flush_active = (state == FLUSH);
endmodule

// File: tb/tb_vip_window_ctrl.sv
// tb_vip_window_ctrl: randomized frames checked by a window scoreboard and per-frame event counts
module tb_vip_window_ctrl;
    localparam int H = 8;
    localparam int V = 4;
    localparam int G = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vip_window_ctrl_if bus ();
    vip_window_ctrl #(.IMG_HDISP(H), .IMG_VDISP(V), .FLUSH_GAP(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        int row;
        int col;
        logic [3:0] fl;
    } win_t;
    win_t exp_q[$];
    int cmp = 0, err = 0;
    int n_shift = 0, n_done = 0, n_abort = 0, n_clr = 0;
    int b_shift, b_done, b_abort, b_clr;
    int exp_shift, exp_done, exp_abort, lg;
    bit exp_err = 0, cut_flush = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        cmp++;
        if (act !== want) begin
            err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask
    function automatic void push(input int r, input int c);
        win_t w;
        w.row = r;
        w.col = c;
        w.fl = {r == 0, r == V - 1, c == 0, c == H - 1};
        exp_q.push_back(w);
    endfunction
    task automatic monitor();
        win_t w;
        forever begin
            @(negedge clk);
            if (bus.shift_en) n_shift++;
            if (bus.frame_done) n_done++;
            if (bus.frame_abort) n_abort++;
            if (bus.buf_clr) n_clr++;
            if (bus.win_valid) begin
                if (exp_q.size() == 0) begin
                    cmp++;
                    err++;
                    $display("FAIL unexpected_window: got row %0d col %0d, want no window", bus.win_row, bus.win_col);
                end else begin
                    w = exp_q.pop_front();
                    chk("win_row", 32'(bus.win_row), w.row);
                    chk("win_col", 32'(bus.win_col), w.col);
                    chk("win_flags", {bus.edge_top, bus.edge_bot, bus.edge_left, bus.edge_right}, w.fl);
                end
            end else chk("flags_idle", {bus.edge_top, bus.edge_bot, bus.edge_left, bus.edge_right}, 0);
        end
    endtask
    task automatic cyc(input logic vs, input logic hr, input logic ce);
        @(posedge clk);
        #1;
        bus.in_vsync = vs;
        bus.in_href = hr;
        bus.in_clken = ce;
    endtask
    task automatic begin_case();
        b_shift = n_shift;
        b_done = n_done;
        b_abort = n_abort;
        b_clr = n_clr;
        exp_shift = 0;
        exp_done = 0;
        exp_abort = 0;
    endtask
    task automatic end_case(input string nm);
        chk($sformatf("%s_shift", nm), n_shift - b_shift, exp_shift);
        chk($sformatf("%s_done", nm), n_done - b_done, exp_done);
        chk($sformatf("%s_abort", nm), n_abort - b_abort, exp_abort);
        chk($sformatf("%s_seq_err", nm), bus.seq_err, exp_err);
        chk($sformatf("%s_pending", nm), exp_q.size(), 0);
    endtask
    function automatic void flush_model();
        if (cut_flush) begin
            push(V - 1, 0);
            push(V - 1, 1);
            exp_shift += 3;
        end else begin
            for (int c = 0; c < H; c++) push(V - 1, c);
            exp_shift += H;
            exp_done++;
        end
    endfunction
    task automatic frame_start();
        lg = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
    endtask
    task automatic line(input int n);
        int c;
        logic ce;
        c = 0;
        while (c < n) begin
            ce = ($urandom_range(0, 3) != 0);
            cyc(1, 1, ce);
            if (ce) begin
                exp_shift++;
                if (lg >= 1) push(lg - 1, c);
                c++;
            end
        end
        cyc(1, 0, 0);
        if ($urandom_range(0, 1) != 0) cyc(1, 0, 0);
        if (n == H) begin
            lg++;
            if (lg == V) flush_model();
        end else exp_err = 1;
    endtask
    task automatic frame_finish();
        repeat (G + H + 4) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
    endtask
    task automatic full_frame();
        frame_start();
        repeat (V) line(H);
    endtask
    task automatic wait_flush();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.flush_active && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("flush_reached", bus.flush_active, 1);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        bus.in_vsync = 0;
        bus.in_href = 0;
        bus.in_clken = 0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask
    task automatic chk_all_zero(input string nm);
        chk($sformatf("%s_shift_en", nm), bus.shift_en, 0);
        chk($sformatf("%s_buf_clr", nm), bus.buf_clr, 0);
        chk($sformatf("%s_win_valid", nm), bus.win_valid, 0);
        chk($sformatf("%s_flush_active", nm), bus.flush_active, 0);
        chk($sformatf("%s_frame_done", nm), bus.frame_done, 0);
        chk($sformatf("%s_frame_abort", nm), bus.frame_abort, 0);
        chk($sformatf("%s_seq_err", nm), bus.seq_err, 0);
        chk($sformatf("%s_win_pos", nm), {bus.win_row, bus.win_col}, 0);
        chk($sformatf("%s_edges", nm), {bus.edge_top, bus.edge_bot, bus.edge_left, bus.edge_right}, 0);
    endtask
    initial begin
        bus.in_vsync = 1;
        bus.in_href = 1;
        bus.in_clken = 1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1;
        begin_case();
        repeat (4) cyc(1, 1, 1);
        chk("no_start_after_reset", n_clr - b_clr, 0);
        end_case("post_reset");
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            begin_case();
            full_frame();
            frame_finish();
            chk("frame_buf_clr", n_clr - b_clr, 1);
            end_case("nominal");
        end
        begin_case();
        frame_start();
        line(H);
        line(5);
        repeat (V - 1) line(H);
        frame_finish();
        end_case("short_line");
        do_reset();
        begin_case();
        frame_start();
        line(H);
        line(H);
        cyc(0, 0, 0);
        exp_abort++;
        repeat (G + H + 4) cyc(0, 0, 0);
        end_case("abort");
        begin_case();
        full_frame();
        frame_finish();
        end_case("after_abort");
        begin_case();
        full_frame();
        wait_flush();
        repeat (3) cyc(1, 1, 1);
        cyc(1, 0, 0);
        exp_err = 1;
        frame_finish();
        end_case("late_pixels");
        do_reset();
        begin_case();
        cut_flush = 1;
        full_frame();
        wait_flush();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk_all_zero("reset_in_flush");
        cut_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        b_clr = n_clr;
        repeat (4) cyc(1, 0, 0);
        chk("no_restart_without_rise", n_clr - b_clr, 0);
        end_case("reset_in_flush");
        begin_case();
        full_frame();
        frame_finish();
        end_case("after_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/vip_window_ctrl.md
VIP_WINDOW_CTRL -- requirements
Module: vip_window_ctrl

Interface
REQ-001 Parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 Parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 Parameter FLUSH_GAP, default 16, idle cycles between the last input line and the synthetic flush line.
REQ-004 clk  in  1  video pixel clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_vsync  in  1  frame valid, high for the whole frame.
REQ-007 in_href  in  1  line valid.
REQ-008 in_clken  in  1  pixel qualifier; a pixel is accepted when in_href && in_clken.
REQ-009 shift_en  out  1  line-buffer shift enable, combinational: accepted pixel or flush pixel.
REQ-010 buf_clr  out  1  one-cycle pulse clearing the line buffers.
REQ-011 win_valid  out  1  3x3 window centre is valid; registered.
REQ-012 win_col  out  11  centre column; win_row  out  11  centre row.
REQ-013 edge_top, edge_bot, edge_left, edge_right  out  1 each  mirror-select flags for the centre pixel.
REQ-014 flush_active  out  1  high while the FSM is in FLUSH.
REQ-015 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-016 frame_abort  out  1  one-cycle pulse when a frame is abandoned.
REQ-017 seq_err  out  1  sticky error flag; cleared only by reset.

Function
REQ-018 The FSM SHALL have states IDLE, ACTIVE, FLUSH_WAIT, FLUSH and DONE.
REQ-019 IDLE->ACTIVE SHALL occur on a rising edge of in_vsync; buf_clr pulses in that same cycle.
REQ-020 In ACTIVE, each accepted pixel SHALL assert shift_en and increment px (0..IMG_HDISP-1).
REQ-021 In ACTIVE, a falling edge of in_href with px==IMG_HDISP SHALL increment ln and clear px.
REQ-022 A falling edge of in_href with px!=IMG_HDISP SHALL set seq_err, clear px and leave ln unchanged.
REQ-023 ACTIVE->FLUSH_WAIT SHALL occur when ln reaches IMG_VDISP.
REQ-024 FLUSH_WAIT SHALL count FLUSH_GAP cycles, then go to FLUSH.
REQ-025 FLUSH SHALL assert shift_en for exactly IMG_HDISP consecutive cycles, then go to DONE.
REQ-026 DONE SHALL pulse frame_done for one cycle, then go to IDLE.
REQ-027 Pixels accepted in FLUSH_WAIT, FLUSH or DONE SHALL be ignored (no shift_en) and SHALL set seq_err.
REQ-028 in_vsync falling in ACTIVE, FLUSH_WAIT or FLUSH SHALL return the FSM to IDLE and pulse frame_abort.
REQ-029 An aborted frame SHALL produce no flush line and no frame_done.
REQ-030 win_valid SHALL be high one cycle after every shift_en cycle, except for shift_en cycles on input line 0.
REQ-031 win_row SHALL be ln-1 in ACTIVE and IMG_VDISP-1 for flush pixels.
REQ-032 win_col SHALL be the px value of the originating shift cycle.
REQ-033 edge_top SHALL be (win_row==0) and edge_bot (win_row==IMG_VDISP-1).
REQ-034 edge_left SHALL be (win_col==0) and edge_right (win_col==IMG_HDISP-1).
REQ-035 All flags SHALL be registered with win_valid; they are 0 whenever win_valid is 0.
REQ-036 The latency from shift_en to win_valid SHALL be exactly one cycle.
REQ-037 Counters SHALL never wrap: px saturates at IMG_HDISP and ln at IMG_VDISP.

Reset
REQ-038 rst_n low SHALL force state IDLE, px=0, ln=0 and every output 0, including seq_err.
REQ-039 Reset asserted mid-frame SHALL take effect immediately; the next frame starts only on a new in_vsync rising edge.

Structure
REQ-040 Package vip_win_pkg SHALL hold the state enum, the counter width constant (11) and the flag bit positions.
REQ-041 Sub-module vip_edge_detect (registered rise/fall pulses) SHALL be instantiated once each for in_vsync and in_href.

Verification (IMG_HDISP=8, IMG_VDISP=4, FLUSH_GAP=2)
REQ-042 Nominal frame: 4 lines x 8 pixels -> 32 input shift_en, then after 2 idle cycles 8 flush shift_en; win_valid count 32; frame_done pulses once.
REQ-043 Edges: on the first window, edge_top=1 and edge_left=1 with win_row=0, win_col=0; on the last flush window, edge_bot=1 and edge_right=1 with win_row=3, win_col=7.
REQ-044 Short line: line 1 carries 5 pixels -> seq_err=1, ln stays 1, and the next full line is counted as line 1.
REQ-045 Abort: in_vsync falls after line 2 -> frame_abort pulses, no flush, no frame_done; the next frame completes normally.
REQ-046 Late pixels: pixels injected during FLUSH -> shift_en stays at the 8 flush pulses only; seq_err=1.
REQ-047 Reset during FLUSH (cycle 3) -> all outputs 0 in the same cycle; a subsequent frame behaves exactly as in REQ-042.
